seq_core_fetch: RTL
===================

Name: seq_core_fetch

Overview:
Instruction fetch stage of the pipelined sequential core; sits directly upstream of the decode/read stage and supplies it with the 16-bit instruction register.
- Owns the program counter and drives a synchronous program memory (1-cycle read latency).
- Registers the fetched instruction with a valid flag and its PC.
- Handles downstream stalls through a 1-entry skid buffer, and handles branch redirect (flush) and halt.

Parameters:
A_SIZE, 10, program memory address width (PC width)
I_SIZE, 16, instruction width

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
stall  input  1  downstream cannot accept a new instruction this cycle; hold ir
jmp  input  1  branch taken (from execute); redirect fetch to jmp_addr and flush
jmp_addr  input  A_SIZE  branch target
halt  input  1  HALT executed; stop fetching permanently until reset
pmem_rd  output  1  program memory read enable
pmem_addr  output  A_SIZE  program memory read address, equals pc
pmem_data  input  I_SIZE  read data, valid the cycle after pmem_rd=1
ir  output  I_SIZE  instruction to decode stage (registered)
ir_valid  output  1  ir holds a real instruction
ir_pc  output  A_SIZE  address ir was fetched from (for relative jumps)
halted  output  1  core halted

Behaviour:
- Reset is asynchronous, active-high, and may occur mid-operation. Asserting rst immediately sets:
  - pc=0, state=START, req_valid=0, req_pc=0, skid_valid=0, skid=0, skid_pc=0
  - ir=0, ir_valid=0, ir_pc=0, halted=0
  - pmem_rd=0 (pmem_rd is decoded from state)
  - Any in-flight read is discarded.
- States:
  - START: one cycle after reset release, pmem_rd=0; always moves to RUN.
  - RUN: normal operation.
  - HALT: terminal until rst.
- pmem_addr = pc, combinational.
- pmem_rd = (state==RUN) && !stall && !jmp && !halt.
- When pmem_rd=1, at the clock edge: pc <= pc+1, modulo 2^A_SIZE (wraps from all-ones to 0).
- Request tracking, every edge: req_valid <= pmem_rd and req_pc <= pc. Data for a request arrives on pmem_data in the following cycle.
- Event priority per cycle: halt > jmp > stall > normal.
- halt=1 (in START or RUN):
  - Next state HALT; halted <= 1; ir_valid <= 0; req_valid and skid_valid cleared.
  - In HALT: pmem_rd=0 and ir_valid=0; jmp and stall are ignored; pc frozen.
- jmp=1 (no halt):
  - pc <= jmp_addr; ir_valid <= 0.
  - Arriving data (req_valid) and any skid entry are discarded; skid_valid <= 0.
  - The first target read is issued in the next cycle.
- stall=1 (no halt/jmp):
  - ir, ir_valid and ir_pc are held.
  - If req_valid: skid <= pmem_data, skid_pc <= req_pc, skid_valid <= 1.
  - Since pmem_rd=0, at most one word can be in flight, so the skid entry cannot overflow.
- Normal cycle (no stall), in priority order:
  - If skid_valid: ir <= skid, ir_pc <= skid_pc, ir_valid <= 1, skid_valid <= 0.
  - Else if req_valid: ir <= pmem_data, ir_pc <= req_pc, ir_valid <= 1.
  - Else: ir_valid <= 0, and ir/ir_pc keep their previous value.
  - skid_valid and req_valid are never both 1 in a non-stall cycle, because pmem_rd=0 during the stall that filled the skid.
- Latency: after rst release, address 0 is issued in cycle 1 and ir_valid=1 with ir=mem[0] in cycle 3. Thereafter one instruction per cycle without bubbles.
- Redirect penalty: jmp in cycle t gives ir_valid=0 in t+1 and t+2, then ir=mem[jmp_addr] in t+3.
- No instruction is ever duplicated or dropped across a stall.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds output port fetch_count (32 bits). It resets to 0 and increments by 1 on every edge where ir_valid is loaded with 1 from skid or pmem_data; held values during a stall are not counted. It wraps at 2^32.
- Undefined: the port and counter are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset release, mem[i]=16'h1000+i, no stall → pmem_addr 0,1,2 in cycles 1,2,3; cycle 3 ir=16'h1000, ir_pc=0, ir_valid=1; then 1001, 1002 back-to-back.
- stall high 2 cycles while ir=16'h1004 and addr 5 is in flight → ir holds 1004, pmem_rd=0; after release ir=1005 then 1006, no duplicate or gap.
- jmp=1, jmp_addr=0x20 while ir=16'h1003 → next cycle pmem_addr=0x20 and ir_valid=0 for 2 cycles; then ir=16'h1020, ir_pc=0x20; 1004 never delivered.
- jmp and stall together with a skid entry pending → jmp wins: skid cleared, same sequence as the previous scenario.
- halt=1 with jmp=1 the same cycle → halted=1 next cycle, pmem_rd=0 and ir_valid=0 indefinitely, pc frozen; async rst pulse mid-cycle returns all outputs to reset values immediately.
- A_SIZE=4, run 20 cycles → pmem_addr wraps 15→0, ir_pc follows. With FETCH_PERF_CNT_EN: fetch_count equals the number of ir_valid=1 loads (e.g. 17).

Source files
------------

// File: rtl/seq_core_fetch.sv
// seq_core_fetch: instruction fetch stage of the pipelined sequential core.
// Owns the PC and drives a 1-cycle-latency program memory. It delivers a
// registered instruction, with its valid flag and PC, to decode. A 1-entry skid
// buffer absorbs the word in flight when a stall arrives. The stage also handles
// branch redirect (flush) and a permanent halt.
// Optional: define FETCH_PERF_CNT_EN to add the 32-bit fetch_count output.
module seq_core_fetch #(
  parameter int unsigned A_SIZE = 10,
  parameter int unsigned I_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              jmp,
  input  logic [A_SIZE-1:0] jmp_addr,
  input  logic              halt,
  output logic              pmem_rd,
  output logic [A_SIZE-1:0] pmem_addr,
  input  logic [I_SIZE-1:0] pmem_data,
  output logic [I_SIZE-1:0] ir,
  output logic              ir_valid,
  output logic [A_SIZE-1:0] ir_pc,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t            state;
  logic [A_SIZE-1:0] pc;
  logic              req_valid;
  logic [A_SIZE-1:0] req_pc;
  logic              skid_valid;
  logic [I_SIZE-1:0] skid;
  logic [A_SIZE-1:0] skid_pc;

  // Read request is issued only in RUN when no higher-priority event is present
  assign pmem_rd   = (state == ST_RUN) && !stall && !jmp && !halt;
  assign pmem_addr = pc;

  // Fetch control: PC, request tracking, skid buffer and instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_START;
      pc         <= '0;
      req_valid  <= 1'b0;
      req_pc     <= '0;
      skid_valid <= 1'b0;
      skid       <= '0;
      skid_pc    <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      ir_pc      <= '0;
      halted     <= 1'b0;
    end else begin
      req_valid <= pmem_rd;
      req_pc    <= pc;
      if (pmem_rd) begin
        pc <= pc + A_SIZE'(1);
      end
      case (state)
        ST_START, ST_RUN: begin
          if (state == ST_START) begin
            state <= ST_RUN;
          end
          if (halt) begin
            state      <= ST_HALT;
            halted     <= 1'b1;
            ir_valid   <= 1'b0;
            req_valid  <= 1'b0;
            skid_valid <= 1'b0;
          end else if (jmp) begin
            // Redirect: the word arriving now and any skid entry are stale
            pc         <= jmp_addr;
            ir_valid   <= 1'b0;
            skid_valid <= 1'b0;
          end else if (stall) begin
            // Hold ir; park the word arriving this cycle so it is not lost
            if (req_valid) begin
              skid       <= pmem_data;
              skid_pc    <= req_pc;
              skid_valid <= 1'b1;
            end
          end else if (skid_valid) begin
            ir         <= skid;
            ir_pc      <= skid_pc;
            ir_valid   <= 1'b1;
            skid_valid <= 1'b0;
          end else if (req_valid) begin
            ir       <= pmem_data;
            ir_pc    <= req_pc;
            ir_valid <= 1'b1;
          end else begin
            ir_valid <= 1'b0;
          end
        end
        ST_HALT: begin
          ir_valid <= 1'b0;
        end
        default: begin
          state <= ST_START;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic ir_load_c;

  assign ir_load_c = (state != ST_HALT) && !halt && !jmp && !stall && (skid_valid || req_valid);

  // Count every edge that loads ir with a real instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
    end else if (ir_load_c) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule
